// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state codes,
// the bubble word and the default reset PC.
package fetch_unit_pkg;

    // All-zero word; opcode 7'b0000000 decodes as a NOP downstream.
    localparam logic [31:0] BUBBLE_WORD      = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM state encoding.
    typedef logic [2:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 3'd0;
    localparam fetch_state_t ST_REQ  = 3'd1;
    localparam fetch_state_t ST_WAIT = 3'd2;
    localparam fetch_state_t ST_HOLD = 3'd3;
    localparam fetch_state_t ST_DROP = 3'd4;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/grant/response bus between the fetch unit
// (master) and instruction memory (slave).
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register and its next-value selection:
// reset value, redirect target, sequential +4, or hold.
module fetch_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        advance,
    output logic [31:0] pc,
    output logic        misaligned
);

    logic [31:0] pc_next;

    // Redirect wins over sequential advance; otherwise the PC holds.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = word_align(target);
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

    // Flag a redirect whose target is not word-aligned.
    always_comb begin
        misaligned = redirect && (target[1:0] != 2'b00);
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= word_align(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time,
// buffers a response while decode stalls, discards responses made stale
// by a redirect, and drives the IF/ID pipeline register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] BUBBLE   = BUBBLE_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_D,
    input  logic                redirect_E,
    input  logic [31:0]         target_E,
    fetch_unit_if.master        imem,
    output logic [31:0]         instruction_D,
    output logic [31:0]         pc_D,
    output logic [31:0]         pc_plus4_D,
    output logic                valid_D,
    output logic                misalign_F
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  stale_addr;
    logic         drop_pending;
    logic [31:0]  hold_buf;
    logic         misaligned;
    logic         gnt_fire;
    logic         resp;
    logic         deliver_mem;
    logic         deliver_hold;
    logic         advance;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect_E),
        .target     (target_E),
        .advance    (advance),
        .pc         (pc),
        .misaligned (misaligned)
    );

    // Handshake qualifiers; rvalid only counts while a response is awaited.
    always_comb begin
        gnt_fire     = (state == ST_REQ) && imem.imem_gnt;
        resp         = (state == ST_WAIT) && imem.imem_rvalid;
        deliver_mem  = resp && !stall_D && !redirect_E;
        deliver_hold = (state == ST_HOLD) && !stall_D && !redirect_E;
        advance      = deliver_mem || deliver_hold;
    end

    // Request outputs; a redirect during an ungranted request keeps the old
    // address on the bus until the grant so the request stays stable.
    always_comb begin
        imem.imem_req  = (state == ST_REQ);
        imem.imem_addr = ((state == ST_REQ) && drop_pending) ? stale_addr : pc;
        pc_plus4_D     = pc_D + 32'd4;
    end

    // Next-state logic. A redirect in WAIT normally leaves a response in
    // flight (DROP), but if that response arrives in the same cycle it is
    // already consumed, so the FSM goes straight back to REQ.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (gnt_fire) begin
                    state_next = (redirect_E || drop_pending) ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_E) begin
                    state_next = imem.imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem.imem_rvalid) begin
                    state_next = stall_D ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_E || !stall_D) begin
                    state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem.imem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Track a redirect that hit an ungranted request and freeze its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pending <= 1'b0;
            stale_addr   <= word_align(RESET_PC);
        end else if (state == ST_REQ) begin
            if (gnt_fire) begin
                drop_pending <= 1'b0;
            end else if (redirect_E) begin
                drop_pending <= 1'b1;
                if (!drop_pending) begin
                    stale_addr <= pc;
                end
            end
        end else begin
            drop_pending <= 1'b0;
        end
    end

    // One-entry hold buffer for a word that arrives while decode is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_buf <= BUBBLE;
        end else if (redirect_E) begin
            hold_buf <= BUBBLE;
        end else if (resp && stall_D) begin
            hold_buf <= imem.imem_rdata;
        end
    end

    // IF/ID register: redirect flushes, stall holds, otherwise load a ready
    // word or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction_D <= BUBBLE;
            pc_D          <= 32'h0000_0000;
            valid_D       <= 1'b0;
        end else if (redirect_E) begin
            instruction_D <= BUBBLE;
            valid_D       <= 1'b0;
        end else if (deliver_mem) begin
            instruction_D <= imem.imem_rdata;
            pc_D          <= pc;
            valid_D       <= 1'b1;
        end else if (deliver_hold) begin
            instruction_D <= hold_buf;
            pc_D          <= pc;
            valid_D       <= 1'b1;
        end else if (!stall_D) begin
            instruction_D <= BUBBLE;
            valid_D       <= 1'b0;
        end
    end

    // Misaligned-redirect pulse, high for the cycle after the redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_F <= 1'b0;
        end else begin
            misalign_F <= misaligned;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and decoded
// instructions are queued by the stimulus; monitors pop and compare them
// whenever a request is granted or decode consumes an instruction.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_D = 1'b0;
    logic        redirect_E = 1'b0;
    logic [31:0] target_E = 32'h0;
    logic [31:0] instruction_D, pc_D, pc_plus4_D;
    logic        valid_D, misalign_F;

    logic        stall_D1 = 1'b0;
    logic        redirect_E1 = 1'b0;
    logic [31:0] target_E1 = 32'h0;
    logic [31:0] instruction_D1, pc_D1, pc_plus4_D1;
    logic        valid_D1, misalign_F1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    exp_t        exp1_q[$];
    logic [31:0] addr1_q[$];

    int   lat = 1;
    logic gnt_en = 1'b1;
    logic poison = 1'b0;
    logic gap_en = 1'b0;

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();

    fetch_unit dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_D       (stall_D),
        .redirect_E    (redirect_E),
        .target_E      (target_E),
        .imem          (bus0),
        .instruction_D (instruction_D),
        .pc_D          (pc_D),
        .pc_plus4_D    (pc_plus4_D),
        .valid_D       (valid_D),
        .misalign_F    (misalign_F)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_D       (stall_D1),
        .redirect_E    (redirect_E1),
        .target_E      (target_E1),
        .imem          (bus1),
        .instruction_D (instruction_D1),
        .pc_D          (pc_D1),
        .pc_plus4_D    (pc_plus4_D1),
        .valid_D       (valid_D1),
        .misalign_F    (misalign_F1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between grants.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic redirect,
                                 input logic [31:0] target);
        stall_D    = stall;
        redirect_E = redirect;
        target_E   = target;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pushInstr(input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] plus4);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.plus4 = plus4;
        exp_q.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"},      bus0.imem_req, 1'b0);
        checkOutput({tag, "_addr"},     bus0.imem_addr, 32'h0);
        checkOutput({tag, "_instr"},    instruction_D, BUBBLE_WORD);
        checkOutput({tag, "_pc_D"},     pc_D, 32'h0);
        checkOutput({tag, "_plus4"},    pc_plus4_D, 32'h4);
        checkOutput({tag, "_valid"},    valid_D, 1'b0);
        checkOutput({tag, "_misalign"}, misalign_F, 1'b0);
        checkOutput({tag, "_addr1"},    bus1.imem_addr, 32'hFFFF_FFFC);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        checkResetValues(tag);
        checkOutput({tag, "_leftover"}, exp_q.size() + addr_q.size(), 0);
    endtask

    // Instruction memory for dut0: programmable grant enable and latency.
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        pend_poison = 1'b0;
    initial begin : mem0
        bus0.imem_gnt    = 1'b0;
        bus0.imem_rvalid = 1'b0;
        bus0.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus0.imem_req && bus0.imem_gnt) begin
                pend        = 1'b1;
                pend_cnt    = lat;
                pend_addr   = bus0.imem_addr;
                pend_poison = poison;
            end
            @(posedge clk);
            #1;
            bus0.imem_rvalid = 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    bus0.imem_rvalid = 1'b1;
                    bus0.imem_rdata  = memWord(pend_addr) ^ (pend_poison ? 32'hFFFF_0000 : 32'h0);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            bus0.imem_gnt = bus0.imem_req && gnt_en;
        end
    end

    // Zero-wait instruction memory for dut1.
    logic        pend1 = 1'b0;
    logic [31:0] pend1_addr = 32'h0;
    initial begin : mem1
        bus1.imem_gnt    = 1'b0;
        bus1.imem_rvalid = 1'b0;
        bus1.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus1.imem_req && bus1.imem_gnt) begin
                pend1      = 1'b1;
                pend1_addr = bus1.imem_addr;
            end
            @(posedge clk);
            #1;
            bus1.imem_rvalid = pend1;
            if (pend1) begin
                bus1.imem_rdata = memWord(pend1_addr);
                pend1 = 1'b0;
            end
            bus1.imem_gnt = bus1.imem_req;
        end
    end

    // dut0 monitor: grants, request stability, grant spacing, consumption.
    logic        prev_req = 1'b0;
    logic        prev_fire = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        have_last = 1'b0;
    int          last_cyc = 0;
    initial begin : mon0
        logic fire;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) have_last = 1'b0;
            if (bus0.imem_req && prev_req && !prev_fire)
                checkOutput("addr_stable", bus0.imem_addr, prev_addr);
            fire = bus0.imem_req && bus0.imem_gnt;
            if (fire) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL fetch_extra: got addr %h, expected no request", bus0.imem_addr);
                end else begin
                    checkOutput("fetch_addr", bus0.imem_addr, addr_q.pop_front());
                end
                if (gap_en && have_last)
                    checkOutput("fetch_gap", cyc - last_cyc, 2);
                last_cyc  = cyc;
                have_last = 1'b1;
            end
            prev_req  = bus0.imem_req;
            prev_fire = fire;
            prev_addr = bus0.imem_addr;
            if (valid_D && !stall_D) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL instr_extra: got pc %h instr %h, expected none", pc_D, instruction_D);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("instr_pc", pc_D, e.pc);
                    checkOutput("instr_word", instruction_D, e.instr);
                    checkOutput("instr_plus4", pc_plus4_D, e.plus4);
                end
            end
        end
    end

    // dut1 monitor: only its first fetches after the first reset are scored.
    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus1.imem_req && bus1.imem_gnt && addr1_q.size() > 0)
                checkOutput("wrap_fetch_addr", bus1.imem_addr, addr1_q.pop_front());
            if (valid_D1 && exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                checkOutput("wrap_pc", pc_D1, e.pc);
                checkOutput("wrap_instr", instruction_D1, e.instr);
                checkOutput("wrap_plus4", pc_plus4_D1, e.plus4);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios, each starting from a fresh reset.
    initial begin : stim
        exp_t e1;
        #1;
        doReset("rst0");

        // Zero-wait stream from RESET_PC and the wrapping instance.
        lat = 1; gnt_en = 1'b1; gap_en = 1'b1;
        addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        pushInstr(32'h0, 32'h0050_0093, 32'h4);
        pushInstr(32'h4, 32'h0050_0097, 32'h8);
        pushInstr(32'h8, 32'h0050_009B, 32'hC);
        addr1_q = '{32'hFFFF_FFFC, 32'h0};
        e1.pc = 32'hFFFF_FFFC; e1.instr = 32'hFFAF_FF6F; e1.plus4 = 32'h0;
        exp1_q.push_back(e1);
        rst_n = 1'b1;
        step(); checkOutput("s1_valid_c1", valid_D, 1'b0);
        step(); checkOutput("s1_valid_c2", valid_D, 1'b0);
        step(); checkOutput("s1_valid_c3", valid_D, 1'b1);
        checkOutput("s1_pc_c3", pc_D, 32'h0);
        repeat (5) step();
        gap_en = 1'b0;
        doReset("rst1");
        checkOutput("wrap_leftover", exp1_q.size() + addr1_q.size(), 0);

        // Decode stall across a returning word.
        addr_q = '{32'h0, 32'h4, 32'h8};
        pushInstr(32'h0, 32'h0050_0093, 32'h4);
        pushInstr(32'h4, 32'h0050_0097, 32'h8);
        rst_n = 1'b1;
        step();
        step(); applyStimulus(1'b1, 1'b0, 32'h0);
        step(); checkOutput("s2_req_c3", bus0.imem_req, 1'b0);
        checkOutput("s2_instr_c3", instruction_D, BUBBLE_WORD);
        step(); checkOutput("s2_req_c4", bus0.imem_req, 1'b0);
        checkOutput("s2_instr_c4", instruction_D, BUBBLE_WORD);
        step(); checkOutput("s2_req_c5", bus0.imem_req, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        step(); checkOutput("s2_instr_c6", instruction_D, 32'h0050_0093);
        checkOutput("s2_valid_c6", valid_D, 1'b1);
        checkOutput("s2_req_c6", bus0.imem_req, 1'b1);
        checkOutput("s2_addr_c6", bus0.imem_addr, 32'h4);
        repeat (3) step();
        doReset("rst2");

        // Redirect while waiting: the in-flight word must be dropped.
        lat = 2;
        addr_q = '{32'h0, 32'h100, 32'h104};
        pushInstr(32'h100, 32'h0050_0193, 32'h104);
        rst_n = 1'b1;
        step();
        step(); applyStimulus(1'b0, 1'b1, 32'h100);
        step(); applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("s3_valid_c3", valid_D, 1'b0);
        checkOutput("s3_req_c3", bus0.imem_req, 1'b0);
        checkOutput("s3_misalign_c3", misalign_F, 1'b0);
        step(); checkOutput("s3_valid_c4", valid_D, 1'b0);
        checkOutput("s3_addr_c4", bus0.imem_addr, 32'h100);
        step();
        step();
        step(); checkOutput("s3_valid_c7", valid_D, 1'b1);
        checkOutput("s3_pc_c7", pc_D, 32'h100);
        step();
        doReset("rst3");

        // Misaligned redirect during an ungranted request.
        lat = 1; gnt_en = 1'b0;
        addr_q = '{32'h0, 32'h100, 32'h104};
        pushInstr(32'h100, 32'h0050_0193, 32'h104);
        rst_n = 1'b1;
        step(); applyStimulus(1'b0, 1'b1, 32'h102);
        step(); applyStimulus(1'b0, 1'b0, 32'h0);
        gnt_en = 1'b1;
        checkOutput("s4_addr_frozen", bus0.imem_addr, 32'h0);
        checkOutput("s4_misalign_c2", misalign_F, 1'b1);
        step(); checkOutput("s4_misalign_c3", misalign_F, 1'b0);
        step(); checkOutput("s4_req_drop", bus0.imem_req, 1'b0);
        step(); checkOutput("s4_addr_c5", bus0.imem_addr, 32'h100);
        checkOutput("s4_req_c5", bus0.imem_req, 1'b1);
        step();
        step(); checkOutput("s4_pc_c7", pc_D, 32'h100);
        step();
        doReset("rst4");

        // Reset while waiting, then a stray response after release.
        lat = 3; poison = 1'b1;
        addr_q = '{32'h0, 32'h0, 32'h4};
        pushInstr(32'h0, 32'h0050_0093, 32'h4);
        rst_n = 1'b1;
        step();
        step(); poison = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_req_async", bus0.imem_req, 1'b0);
        step(); checkResetValues("s5_rst");
        lat = 1;
        rst_n = 1'b1;
        step(); checkOutput("s5_valid_c4", valid_D, 1'b0);
        checkOutput("s5_addr_c4", bus0.imem_addr, 32'h0);
        step(); checkOutput("s5_valid_c5", valid_D, 1'b0);
        checkOutput("s5_instr_c5", instruction_D, BUBBLE_WORD);
        step(); checkOutput("s5_valid_c6", valid_D, 1'b1);
        checkOutput("s5_instr_c6", instruction_D, 32'h0050_0093);
        step();
        doReset("rst5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUBBLE, default 32'h0000_0000, is the all-zero instruction word. The decoder treats opcode 7'b0000000 as NOP, so BUBBLE presents as a NOP downstream.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  the single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall_D  in  1  decode cannot accept a new instruction this cycle.
REQ-007 redirect_E  in  1  a taken branch or jump resolved downstream.
REQ-008 target_E  in  32  redirect target address.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  request address; always word-aligned.
REQ-011 imem_gnt  in  1  the request is accepted in the cycle imem_req and imem_gnt are both high.
REQ-012 imem_rvalid  in  1  read data valid; at most one response per grant, arriving 1 or more cycles after the grant.
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 instruction_D  out  32  IF/ID instruction register; feeds the decoder.
REQ-015 pc_D  out  32  PC of instruction_D.
REQ-016 pc_plus4_D  out  32  pc_D+4, modulo 2^32.
REQ-017 valid_D  out  1  instruction_D holds a real instruction.
REQ-018 misalign_F  out  1  one-cycle pulse: redirect target had target_E[1:0] != 0.

Function
REQ-019 The FSM shall have four states:
- IDLE: 1 cycle, entered at reset.
- REQ: imem_req=1, waiting for gnt.
- WAIT: granted, waiting for rvalid.
- HOLD: response buffered while stall_D is high.
REQ-020 A fifth state, DROP, shall mean a stale response is outstanding and must be discarded.
REQ-021 Transitions shall be:
- IDLE->REQ unconditionally.
- REQ->WAIT on gnt.
- WAIT->REQ on rvalid with stall_D=0.
- WAIT->HOLD on rvalid with stall_D=1.
- HOLD->REQ when stall_D=0.
- DROP->REQ on rvalid.
REQ-022 imem_req shall be 1 only in REQ, and imem_addr shall equal the PC register. Both shall stay stable from the cycle imem_req rises until the cycle of gnt.
REQ-023 Only one request shall be outstanding at a time. Zero-wait throughput shall be one instruction per 2 cycles.
REQ-024 On rvalid in WAIT with stall_D=0 and redirect_E=0, the IF/ID register shall load the following on the next edge:
- instruction_D=imem_rdata;
- pc_D=PC;
- valid_D=1.
REQ-025 In that same case, the PC shall advance to PC+4, wrapping 32'hFFFF_FFFC to 0.
REQ-026 On rvalid with stall_D=1, the word shall go to a one-entry hold buffer and the IF/ID register shall keep its value. The buffer shall be loaded into IF/ID on the first cycle with stall_D=0.
REQ-027 While stall_D=1 and no redirect, the IF/ID register shall hold all fields unchanged.
REQ-028 While stall_D=0 with no instruction ready, the IF/ID register shall load BUBBLE, valid_D=0.
REQ-029 redirect_E shall take priority over stall_D and over rvalid. On the next edge it shall:
- set the PC to {target_E[31:2],2'b00};
- set instruction_D=BUBBLE and valid_D=0;
- empty the hold buffer.
REQ-030 Redirect state transitions shall be:
- from WAIT, or REQ with gnt that cycle: ->DROP;
- from REQ without gnt: stay in REQ with the address frozen until gnt, then ->DROP;
- from IDLE or HOLD: ->REQ.
REQ-031 A redirect with target_E[1:0]!=0 shall set misalign_F=1 for the next cycle only.
REQ-032 imem_rvalid in IDLE, REQ or HOLD shall be ignored.

Reset
REQ-033 On rst_n low, the following shall apply immediately:
- state=IDLE and PC=RESET_PC;
- imem_req=0, imem_addr=RESET_PC;
- instruction_D=BUBBLE, pc_D=0, pc_plus4_D=4;
- valid_D=0, misalign_F=0;
- hold buffer empty.
REQ-034 Reset asserted mid-transaction shall abandon the outstanding response; it is ignored per REQ-032.

Structure
REQ-035 The shared core package shall hold the state enum, BUBBLE and the default RESET_PC.
REQ-036 PC next-value selection (reset/redirect/+4/hold) shall sit in one sub-module, fetch_pc_gen.

Verification
REQ-037 Zero-wait memory (gnt with req, rvalid next cycle), RESET_PC=0 -> imem_addr 0,4,8 every 2 cycles; valid_D first high 3 cycles after reset release, pc_D=0.
REQ-038 stall_D high across rvalid for 0x00500093, held 3 cycles -> instruction_D unchanged and no req while stalled; 0x00500093 appears the cycle after release, then the next req.
REQ-039 redirect_E with target_E=0x100 while in WAIT -> the returning word is discarded, valid_D=0, next imem_addr=0x100.
REQ-040 Redirect to 0x102 -> misalign_F high exactly 1 cycle, fetch at 0x100.
REQ-041 Reset asserted in WAIT, then a stray rvalid after release -> outputs hold reset values and the first fetch is at RESET_PC.
REQ-042 RESET_PC=32'hFFFF_FFFC -> second fetch address 0, pc_plus4_D of the first instruction = 0.
